mem_bus_arbiter: RTL

- Shares one SRAM-like memory port between the instruction-fetch requester (inst) and the data-access requester (data).
- Sits between the CPU core and the memory/bridge.
- Serialises requests with a request/address-accept/data-return handshake and allows one outstanding transaction at a time.
- Data side has priority; an anti-starvation rule guarantees fetch progress.

---
 rtl/mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the fetch requester and the data requester.
// Only one transaction is outstanding at a time. When both sides request, data
// normally wins. After a data completion, a waiting fetch is granted first, so
// fetch cannot be starved. Completion pulses and read data are combinational in
// the cycle the memory responds. Read data is also captured per side and held
// until that side completes again.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // fetch side
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_done,
  output logic [DATA_W-1:0]   inst_rdata,
  // data side
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_done,
  output logic [DATA_W-1:0]   data_rdata,
  // memory side
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_WAIT = 3'd2,
    I_ADDR = 3'd3,
    I_WAIT = 3'd4
  } arbStateT;

  arbStateT          stateR;
  arbStateT          nextStateS;
  logic              lastWasDataR;
  logic              grantDataS;
  logic              grantInstS;
  logic              instDoneS;
  logic              dataDoneS;
  logic [DATA_W-1:0] instRdataR;
  logic [DATA_W-1:0] dataRdataR;

  // Grant decision and transaction progress; grants are only taken in IDLE.
  always_comb begin
    nextStateS = stateR;
    grantDataS = 1'b0;
    grantInstS = 1'b0;
    instDoneS  = 1'b0;
    dataDoneS  = 1'b0;
    case (stateR)
      IDLE: begin
        // A pending fetch beats data only right after a data completion.
        if (data_req && !(inst_req && lastWasDataR)) begin
          grantDataS = 1'b1;
          nextStateS = D_ADDR;
        end else if (inst_req) begin
          grantInstS = 1'b1;
          nextStateS = I_ADDR;
        end else begin
          nextStateS = IDLE;
        end
      end
      D_ADDR: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            dataDoneS  = 1'b1;
            nextStateS = IDLE;
          end else begin
            nextStateS = D_WAIT;
          end
        end else begin
          nextStateS = D_ADDR;
        end
      end
      D_WAIT: begin
        if (mem_data_ok) begin
          dataDoneS  = 1'b1;
          nextStateS = IDLE;
        end else begin
          nextStateS = D_WAIT;
        end
      end
      I_ADDR: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            instDoneS  = 1'b1;
            nextStateS = IDLE;
          end else begin
            nextStateS = I_WAIT;
          end
        end else begin
          nextStateS = I_ADDR;
        end
      end
      I_WAIT: begin
        if (mem_data_ok) begin
          instDoneS  = 1'b1;
          nextStateS = IDLE;
        end else begin
          nextStateS = I_WAIT;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
  end

  // State register plus record of which side completed last (fairness memory).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR       <= IDLE;
      lastWasDataR <= 1'b0;
    end else begin
      stateR <= nextStateS;
      if (dataDoneS) begin
        lastWasDataR <= 1'b1;
      end else if (instDoneS) begin
        lastWasDataR <= 1'b0;
      end else begin
        lastWasDataR <= lastWasDataR;
      end
    end
  end

  // Latch the winner's request on grant; drop mem_req once the address is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wen   <= {BE_W{1'b0}};
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else if (grantDataS) begin
      mem_req   <= 1'b1;
      mem_wr    <= data_wr;
      mem_wen   <= data_wen;
      mem_addr  <= data_addr;
      mem_wdata <= data_wdata;
    end else if (grantInstS) begin
      mem_req   <= 1'b1;
      mem_wr    <= 1'b0;
      mem_wen   <= {BE_W{1'b0}};
      mem_addr  <= inst_addr;
      mem_wdata <= {DATA_W{1'b0}};
    end else if (mem_req && mem_addr_ok) begin
      mem_req <= 1'b0;
    end else begin
      mem_req <= mem_req;
    end
  end

  // Capture response data per side so it stays visible after the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instRdataR <= {DATA_W{1'b0}};
      dataRdataR <= {DATA_W{1'b0}};
    end else begin
      if (instDoneS) begin
        instRdataR <= mem_rdata;
      end else begin
        instRdataR <= instRdataR;
      end
      if (dataDoneS) begin
        dataRdataR <= mem_rdata;
      end else begin
        dataRdataR <= dataRdataR;
      end
    end
  end

  // Done and read data appear in the response cycle itself, without a register stage.
  assign inst_done  = instDoneS;
  assign data_done  = dataDoneS;
  assign inst_rdata = instDoneS ? mem_rdata : instRdataR;
  assign data_rdata = dataDoneS ? mem_rdata : dataRdataR;
  assign busy       = (stateR != IDLE);

  mem_bus_arbiter_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uChecker (
    .clk         (clk),
    .rst         (rst),
    .inst_done   (inst_done),
    .data_done   (data_done),
    .mem_req     (mem_req),
    .mem_addr_ok (mem_addr_ok),
    .mem_wr      (mem_wr),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy)
  );

endmodule

// Structural invariants of the arbiter, kept apart from the datapath.
module mem_bus_arbiter_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  input logic                inst_done,
  input logic                data_done,
  input logic                mem_req,
  input logic                mem_addr_ok,
  input logic                mem_wr,
  input logic [DATA_W/8-1:0] mem_wen,
  input logic [ADDR_W-1:0]   mem_addr,
  input logic [DATA_W-1:0]   mem_wdata,
  input logic                busy
);

  // Only one transaction is ever in flight, so only one side can complete.
  doneExclusive: assert property (@(posedge clk) disable iff (!rst)
    !(inst_done && data_done));

  // A request is only offered downstream while a transaction is active.
  reqImpliesBusy: assert property (@(posedge clk) disable iff (!rst)
    mem_req |-> busy);

  // Completions only happen from an active state.
  doneImpliesBusy: assert property (@(posedge clk) disable iff (!rst)
    (inst_done || data_done) |-> busy);

  // An offered request stays intact until the memory takes it.
  reqFieldsStable: assert property (@(posedge clk) disable iff (!rst)
    (mem_req && !mem_addr_ok) |=> (mem_req && $stable(mem_addr) && $stable(mem_wr)
                                   && $stable(mem_wen) && $stable(mem_wdata)));

endmodule
